risc_fetch_stage: RTL and testbench
===================================

// Module: risc_fetch_stage
// PURPOSE
//  Instruction-fetch (IF) stage of the RISC pipeline. Owns the PC and drives instruction-memory address.
//  Registers fetched IR + PC+1 into the IF/DOF boundary. Resolves next-PC from EX-stage branch controls.
//  On a taken redirect, squashes the wrong-path instructions in IF and DOF. Sits upstream of decode/operand-fetch.
// PARAMETERS
//  PC_W      10           PC / branch-address width
//  IR_W      32           instruction width
//  RESET_PC  10'h000      PC value loaded by reset
//  NOP_IR    32'h00000000 bubble encoding; must decode to RW=0, MW=0, BS=00
// PORTS
//  clk         in   1     rising-edge clock
//  reset       in   1     synchronous, active-high reset
//  stall_i     in   1     hazard hold: freeze PC and IF/DOF register
//  ex_valid_i  in   1     EX-stage instruction is real (not a bubble)
//  bs_i        in   2     BS_EX: 00 inc, 01 cond branch, 10 jump BrA, 11 jump RAA
//  ps_i        in   1     PS_EX: conditional-branch polarity
//  zero_i      in   1     Zero_EX flag
//  bra_i       in   PC_W  BrA_EX branch target
//  raa_i       in   32    RAA_EX register jump target (low PC_W bits used)
//  imem_addr_o out  PC_W  instruction memory address (= pc_if_o, combinational)
//  imem_data_i in   IR_W  instruction memory read data (combinational read)
//  pc_if_o     out  PC_W  current PC (PC_IF)
//  ir_o        out  IR_W  IF/DOF instruction register (IR_IF)
//  pc2_o       out  PC_W  IF/DOF copy of PC+1 (PC2)
//  valid_o     out  1     ir_o holds a real instruction
//  kill_dof_o  out  1     comb.: squash the instruction now in DOF at next edge
// BEHAVIOUR
//  Reset (sync, priority over all): pc_if_o=RESET_PC, ir_o=NOP_IR, pc2_o=0, valid_o=0, state=RUN.
//  redirect = ex_valid_i & ((bs_i==01 & (zero_i^ps_i)) | bs_i==10 | bs_i==11).
//  Target: BrA for 01/10; raa_i[PC_W-1:0] for 11.
//  Fetch latency: 1 clock. Word at PC appears on ir_o after the next edge; pc2_o = PC+1 at the same time.
//  PC arithmetic: modulo 2^PC_W. PC 10'h3FF increments to 10'h000; pc2_o likewise wraps.
//  Per-edge priority: reset > redirect > stall > normal.
//   redirect: PC<=target; ir_o<=NOP_IR; valid_o<=0; state<=FLUSH. Overrides a simultaneous stall_i.
//   stall:    PC, ir_o, pc2_o, valid_o hold.
//   normal:   PC<=PC+1; ir_o<=imem_data_i; pc2_o<=PC+1; valid_o<=1.
//  kill_dof_o = redirect (combinational), so the DOF/EX register loads a bubble.
//  FSM states: RUN, FLUSH.
//   RUN -> FLUSH on redirect. FLUSH -> RUN on next edge unless another redirect occurs (stay FLUSH).
//   In FLUSH, the EX stage holds the squashed bubble. ex_valid_i=0 there, so no redirect can arise from it.
//   FLUSH otherwise fetches normally at the target.
//  Redirect cost: 2 bubbles, from the slots squashed in IF and DOF.
//  Stall asserted in FLUSH: hold as in RUN; state stays FLUSH until a non-stalled edge.
//  Reset mid-redirect or mid-stall: state discarded; fetch restarts at RESET_PC.
// CONFIGURATION
//  DELAY_SLOT_EN defined:
//   Architectural delay slots, with no squashing. kill_dof_o is tied 0 and redirect loads ir_o from imem normally.
//   The FSM is held in RUN. The two instructions after a taken branch execute.
//  DELAY_SLOT_EN undefined: squash behaviour as above.
// TESTING
//  1. Reset high for 2 clks, imem[i]=32'h1000_0000+i. Release reset.
//     -> pc_if_o=0. After 1 edge: ir_o=32'h10000000, pc2_o=1, valid_o=1.
//     -> PC increments by 1 per clk.
//  2. Set PC to 10'h3FF via jump, then run.
//     -> next pc_if_o=10'h000; pc2_o=10'h000 registered with imem[3FF].
//  3. bs_i=01, ps_i=0, zero_i=1, bra_i=10'h040, ex_valid_i=1 for 1 clk.
//     -> kill_dof_o=1 that cycle; next: pc_if_o=040, ir_o=NOP_IR, valid_o=0.
//     -> following edge: ir_o=imem[040]. Repeat with zero_i=0: no redirect.
//  4. bs_i=11, raa_i=32'hFFFF_F123 with stall_i=1 same cycle.
//     -> pc_if_o=10'h123 next (redirect beats stall). Also ex_valid_i=0 with bs_i=10: no redirect.
//  5. stall_i=1 for 3 clks mid-stream.
//     -> pc_if_o, ir_o, pc2_o, valid_o unchanged for 3 edges; resume at PC+1 after.
//  6. Assert reset during FLUSH.
//     -> next edge: pc_if_o=RESET_PC, valid_o=0. Under DELAY_SLOT_EN, rerun test 3:
//     -> kill_dof_o=0; ir_o=imem[PC] (not NOP) on the redirect edge.

Source files
------------

// File: rtl/risc_fetch_stage.sv
// risc_fetch_stage: instruction-fetch stage of the RISC pipeline.
// It owns the PC, drives the instruction-memory address, and registers the fetched
// instruction with PC+1 into the IF/DOF boundary. It also resolves the next PC from
// the branch controls that come back from the EX stage.
// Build option: define DELAY_SLOT_EN for architectural delay slots. In that mode
// nothing is squashed and the FSM stays in RUN. When the macro is undefined, a taken
// redirect squashes the instructions in IF and DOF.
module risc_fetch_stage #(
  parameter int unsigned      PC_W     = 10,
  parameter int unsigned      IR_W     = 32,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [IR_W-1:0]  NOP_IR   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            ex_valid_i,
  input  logic [1:0]      bs_i,
  input  logic            ps_i,
  input  logic            zero_i,
  input  logic [PC_W-1:0] bra_i,
  input  logic [31:0]     raa_i,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [IR_W-1:0] imem_data_i,
  output logic [PC_W-1:0] pc_if_o,
  output logic [IR_W-1:0] ir_o,
  output logic [PC_W-1:0] pc2_o,
  output logic            valid_o,
  output logic            kill_dof_o
);

  // Branch-select encodings carried by BS_EX.
  localparam logic [1:0] BS_INC  = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_BRA  = 2'b10;
  localparam logic [1:0] BS_RAA  = 2'b11;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [IR_W-1:0] ir_reg;
  logic [PC_W-1:0] pc2_reg;
  logic            valid_reg;

  logic            redirect;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;

  // Only the low PC_W bits of the register jump target address instruction memory.
  logic unused_raa_bits;
  assign unused_raa_bits = ^raa_i[31:PC_W];

  // The PC increments modulo 2^PC_W, so the top address wraps to zero.
  assign pc_inc = pc_reg + PC_W'(1);

  // Resolve redirect and target from the EX-stage branch controls.
  // A bubble in EX (ex_valid_i=0) can never redirect.
  always_comb begin
    redirect = 1'b0;
    target   = bra_i;
    if (ex_valid_i) begin
      unique case (bs_i)
        BS_INC:  redirect = 1'b0;
        BS_COND: redirect = zero_i ^ ps_i;
        BS_BRA:  redirect = 1'b1;
        BS_RAA:  redirect = 1'b1;
        default: redirect = 1'b0;
      endcase
    end
    if (bs_i == BS_RAA) begin
      target = raa_i[PC_W-1:0];
    end
  end

  assign imem_addr_o = pc_reg;
  assign pc_if_o     = pc_reg;
  assign ir_o        = ir_reg;
  assign pc2_o       = pc2_reg;
  assign valid_o     = valid_reg;

`ifdef DELAY_SLOT_EN
  // In delay-slot mode the instructions after a branch are architectural, so DOF
  // is never squashed.
  assign kill_dof_o = 1'b0;

  // PC and IF/DOF register. A redirect only changes where the next fetch comes
  // from. The word fetched this cycle still enters the pipe as a delay slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      ir_reg    <= NOP_IR;
      pc2_reg   <= '0;
      valid_reg <= 1'b0;
      state_reg <= RUN;
    end else if (redirect) begin
      pc_reg    <= target;
      ir_reg    <= imem_data_i;
      pc2_reg   <= pc_inc;
      valid_reg <= 1'b1;
      state_reg <= RUN;
    end else if (stall_i) begin
      pc_reg    <= pc_reg;
      ir_reg    <= ir_reg;
      pc2_reg   <= pc2_reg;
      valid_reg <= valid_reg;
      state_reg <= state_reg;
    end else begin
      pc_reg    <= pc_inc;
      ir_reg    <= imem_data_i;
      pc2_reg   <= pc_inc;
      valid_reg <= 1'b1;
      state_reg <= RUN;
    end
  end
`else
  // A taken redirect turns the instruction now in DOF into a bubble at the next edge.
  assign kill_dof_o = redirect;

  // PC, IF/DOF register and RUN/FLUSH FSM.
  // A redirect beats a simultaneous stall. The wrong-path word in IF is replaced by
  // NOP_IR, and FLUSH marks the cycle whose EX slot holds the squashed bubble.
  // pc2 holds on a redirect: it only has meaning while valid is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      ir_reg    <= NOP_IR;
      pc2_reg   <= '0;
      valid_reg <= 1'b0;
      state_reg <= RUN;
    end else if (redirect) begin
      pc_reg    <= target;
      ir_reg    <= NOP_IR;
      pc2_reg   <= pc2_reg;
      valid_reg <= 1'b0;
      state_reg <= FLUSH;
    end else if (stall_i) begin
      pc_reg    <= pc_reg;
      ir_reg    <= ir_reg;
      pc2_reg   <= pc2_reg;
      valid_reg <= valid_reg;
      state_reg <= state_reg;
    end else begin
      pc_reg    <= pc_inc;
      ir_reg    <= imem_data_i;
      pc2_reg   <= pc_inc;
      valid_reg <= 1'b1;
      state_reg <= RUN;
    end
  end
`endif

endmodule

// File: tb/tb_risc_fetch_stage.sv
// Testbench for risc_fetch_stage.
// The bench runs directed scenarios followed by randomized steps. Every step is
// compared against a behavioural model of the fetch stage. Honours DELAY_SLOT_EN.
module tb_risc_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall_i, ex_valid_i, ps_i, zero_i;
  logic [1:0]  bs_i;
  logic [9:0]  bra_i;
  logic [31:0] raa_i;
  logic [9:0]  imem_addr_o, pc_if_o, pc2_o;
  logic [31:0] imem_data_i, ir_o;
  logic        valid_o, kill_dof_o;

  logic [31:0] imem [1024];
  assign imem_data_i = imem[imem_addr_o];

  always #5 clk = ~clk;

  risc_fetch_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
    .bs_i(bs_i), .ps_i(ps_i), .zero_i(zero_i), .bra_i(bra_i), .raa_i(raa_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i), .pc_if_o(pc_if_o),
    .ir_o(ir_o), .pc2_o(pc2_o), .valid_o(valid_o), .kill_dof_o(kill_dof_o)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model state.
  logic [9:0]  m_pc, m_pc2;
  logic [31:0] m_ir;
  logic        m_valid;
  bit          m_init = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive the inputs, check the combinational outputs, take the edge,
  // advance the model, then check the registered outputs.
  task automatic step(input logic rst, input logic st, input logic exv,
                      input logic [1:0] bs, input logic ps, input logic z,
                      input logic [9:0] bra, input logic [31:0] raa);
    bit taken;
    logic [9:0] tgt;
    reset = rst; stall_i = st; ex_valid_i = exv; bs_i = bs;
    ps_i = ps; zero_i = z; bra_i = bra; raa_i = raa;
    taken = exv && ((bs == 2'd1 && (z != ps)) || bs == 2'd2 || bs == 2'd3);
    tgt   = (bs == 2'd3) ? raa[9:0] : bra;
    #1;
`ifdef DELAY_SLOT_EN
    chk("kill_dof", {31'd0, kill_dof_o}, 32'd0);
`else
    chk("kill_dof", {31'd0, kill_dof_o}, {31'd0, taken});
`endif
    if (m_init) chk("imem_addr", {22'd0, imem_addr_o}, {22'd0, m_pc});
    @(posedge clk);
    if (rst) begin
      m_pc = 10'd0; m_ir = NOP; m_pc2 = 10'd0; m_valid = 0; m_init = 1;
    end else if (taken) begin
`ifdef DELAY_SLOT_EN
      m_ir = imem[m_pc]; m_pc2 = m_pc + 10'd1; m_valid = 1;
`else
      m_ir = NOP; m_valid = 0;
`endif
      m_pc = tgt;
    end else if (!st) begin
      m_ir = imem[m_pc]; m_pc2 = m_pc + 10'd1; m_pc = m_pc + 10'd1; m_valid = 1;
    end
    #1;
    chk("pc_if", {22'd0, pc_if_o}, {22'd0, m_pc});
    chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
    chk("ir", ir_o, m_ir);
    if (m_valid || rst) chk("pc2", {22'd0, pc2_o}, {22'd0, m_pc2});
  endtask

  task automatic idle(input logic st);
    step(1'b0, st, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  logic [9:0]  h_pc, h_pc2;
  logic [31:0] h_ir;

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'h1000_0000 + i;

    // 1. Reset for two clocks, then fetch sequentially.
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    chk("reset_pc", {22'd0, pc_if_o}, 32'd0);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    idle(1'b0);
    chk("first_ir", ir_o, 32'h1000_0000);
    chk("first_pc2", {22'd0, pc2_o}, 32'd1);
    idle(1'b0);
    idle(1'b0);
    chk("seq_pc", {22'd0, pc_if_o}, 32'd3);

    // 2. Jump to 3FF, then fetch across the wrap.
    step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 10'h3FF, 32'd0);
    idle(1'b0);
    chk("wrap_pc", {22'd0, pc_if_o}, 32'd0);
    chk("wrap_pc2", {22'd0, pc2_o}, 32'd0);
    chk("wrap_ir", ir_o, 32'h1000_03FF);

    // 3. Taken conditional branch to 040, then the not-taken polarity.
    h_pc = pc_if_o;
    step(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 10'h040, 32'd0);
    chk("cond_pc", {22'd0, pc_if_o}, 32'h40);
`ifdef DELAY_SLOT_EN
    chk("cond_ir_ds", ir_o, 32'h1000_0000 + {22'd0, h_pc});
`else
    chk("cond_ir", ir_o, NOP);
    chk("cond_valid", {31'd0, valid_o}, 32'd0);
`endif
    idle(1'b0);
    chk("cond_target_ir", ir_o, 32'h1000_0040);
    step(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 10'h200, 32'd0);
    chk("cond_nt_pc", {22'd0, pc_if_o}, 32'h42);

    // 4. A register jump beats a stall, and a bubble in EX never redirects.
    step(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 10'd0, 32'hFFFF_F123);
    chk("raa_pc", {22'd0, pc_if_o}, 32'h123);
    step(1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 10'h300, 32'd0);
    chk("bubble_pc", {22'd0, pc_if_o}, 32'h124);

    // 5. Stall for three clocks in mid-stream, then resume.
    idle(1'b0);
    h_pc = pc_if_o; h_ir = ir_o; h_pc2 = pc2_o;
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk("stall_pc", {22'd0, pc_if_o}, {22'd0, h_pc});
      chk("stall_ir", ir_o, h_ir);
      chk("stall_pc2", {22'd0, pc2_o}, {22'd0, h_pc2});
    end
    idle(1'b0);
    chk("resume_pc", {22'd0, pc_if_o}, {22'd0, h_pc + 10'd1});

    // 6. Reset asserted while the stage is flushing after a jump.
    step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 10'h155, 32'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    chk("flush_reset_pc", {22'd0, pc_if_o}, 32'd0);
    chk("flush_reset_valid", {31'd0, valid_o}, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic r, s, e, p, z;
      logic [1:0] b;
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 3) == 0);
      e = $urandom_range(0, 1);
      b = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      p = $urandom_range(0, 1);
      z = $urandom_range(0, 1);
      step(r, s, e, b, p, z, 10'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
